// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) with EX-stage stall control.
// Ports: clk, rst, start, funct3, flush, op_a, op_b -> stall_EX, done, result.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall_EX,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             isrem_q, isrem_d;

  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, ovf, accept;
  logic [WIDTH:0]   sh, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             last;

  assign is_signed = ~funct3[0];
  assign a_neg     = is_signed & op_a[WIDTH-1];
  assign b_neg     = is_signed & op_b[WIDTH-1];
  assign abs_a     = a_neg ? ('0 - op_a) : op_a;
  assign abs_b     = b_neg ? ('0 - op_b) : op_b;
  assign div_zero  = (op_b == '0);
  assign ovf       = is_signed
                   & (op_a == {1'b1, {(WIDTH-1){1'b0}}})
                   & (op_b == '1);
  assign accept    = start & funct3[2] & ~flush;

  // Shifted partial remainder keeps one extra bit so large
  // unsigned divisors (top bit set) compare correctly.
  assign sh     = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign ge     = (sh >= {1'b0, dvs_q});
  assign rem_nx = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  // Quotient bits shift into the dividend register as it empties.
  assign dvd_nx = {dvd_q[WIDTH-2:0], ge};
  assign q_fix  = negq_q ? ('0 - dvd_nx) : dvd_nx;
  assign r_fix  = negr_q ? ('0 - rem_nx) : rem_nx;
  assign last   = (cnt_q == CW'(WIDTH-1));

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    isrem_d  = isrem_q;
    stall_EX = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_EX = accept;
        if (accept) begin
          isrem_d = funct3[1];
          if (div_zero) begin
            res_d   = funct3[1] ? op_a : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = funct3[1] ? '0 : op_a;
            state_d = DONE;
          end else begin
            dvd_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall_EX = 1'b1;
          dvd_d    = dvd_nx;
          rem_d    = rem_nx;
          cnt_d    = cnt_q + CW'(1);
          if (last) begin
            res_d   = isrem_q ? r_fix : q_fix;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) stall_EX = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic        flush;
  logic [31:0] op_a, op_b;
  logic        stall_EX, done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .flush(flush), .op_a(op_a), .op_b(op_b),
    .stall_EX(stall_EX), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(logic [2:0] f,
                                         logic [31:0] a,
                                         logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'h0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? sa % sb : sa / sb;
    return f[1] ? a % b : a / b;
  endfunction

  // Reference timeline: a normal op keeps the unit busy 32 cycles
  // after acceptance; a special-case op completes right away.
  int          m_left   = 0;
  bit          m_indone = 0;
  logic [31:0] m_result = 0;
  logic [31:0] m_pend   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left   = 0;
      m_indone = 0;
      m_result = 0;
    end else if (m_indone) begin
      m_indone = 0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_indone = 1;
          m_result = m_pend;
        end
      end
    end else if (start && funct3[2] && !flush) begin
      m_pend = ref_op(funct3, op_a, op_b);
      if (op_b == 0 ||
          (!funct3[0] && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF)) begin
        m_indone = 1;
        m_result = m_pend;
      end else m_left = 32;
    end
  end

  bit prev_done = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      bit idle, exp_stall;
      idle = (m_left == 0) && !m_indone;
      exp_stall = !rst && ((idle && start && funct3[2] && !flush) ||
                           (m_left > 0 && !flush));
      check("stall_EX", {31'b0, stall_EX}, {31'b0, exp_stall});
      check("done", {31'b0, done}, {31'b0, m_indone});
      check("result", result, m_result);
      check("done_twice", {31'b0, prev_done & done}, 32'h0);
      prev_done = done;
    end
  end

  task automatic run_op(string nm, logic [2:0] f, logic [31:0] a,
                        logic [31:0] b, logic [31:0] exp, int lat);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    start  = 1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        #1;
        op_a = $urandom;
        op_b = $urandom;
        cyc++;
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 100 cycles", nm);
    end else begin
      check({nm, "_lat"}, cyc, lat);
      check({nm, "_res"}, result, exp);
    end
    @(posedge clk);
    #1;
    start = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic abort_op(bit use_rst, logic [31:0] exp_res);
    start  = 1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    start = 0;
    if (use_rst) rst = 1;
    else flush = 1;
    @(posedge clk);
    #1;
    rst   = 0;
    flush = 0;
    @(negedge clk);
    check(use_rst ? "rst_stall" : "flush_stall", {31'b0, stall_EX}, 32'h0);
    check(use_rst ? "rst_res" : "flush_res", result, exp_res);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    int dcyc[$];
    logic [31:0] dres[$];
    rst    = 1;
    start  = 0;
    funct3 = 3'b000;
    flush  = 0;
    op_a   = 0;
    op_b   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("reset_stall", {31'b0, stall_EX}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_res", result, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("remu_big", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001,
           32'h7FFF_FFFE, 33);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    abort_op(0, 32'hFFFF_FFFF);
    run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("div_m100_7", 3'b100, 32'hFFFF_FF9C, 32'd7,
           32'hFFFF_FFF2, 33);
    abort_op(1, 32'h0);

    start  = 1;
    funct3 = 3'b000;
    repeat (3) begin
      @(negedge clk);
      check("nondiv_stall", {31'b0, stall_EX}, 32'h0);
      @(posedge clk);
      #1;
    end
    funct3 = 3'b101;
    flush  = 1;
    @(negedge clk);
    check("flush_start_stall", {31'b0, stall_EX}, 32'h0);
    @(posedge clk);
    #1;
    flush = 0;
    start = 0;
    @(posedge clk);
    #1;

    start  = 1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        dcyc.push_back(c);
        dres.push_back(result);
      end
      @(posedge clk);
      #1;
      if (c + 1 == 34) begin
        op_a = 32'd9;
        op_b = 32'd3;
      end
      if (c + 1 == 68) start = 0;
    end
    check("b2b_count", dcyc.size(), 32'd2);
    if (dcyc.size() == 2) begin
      check("b2b_cyc0", dcyc[0], 32'd33);
      check("b2b_res0", dres[0], 32'd14);
      check("b2b_cyc1", dcyc[1], 32'd67);
      check("b2b_res1", dres[1], 32'd3);
    end
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
